// File: rtl/mux8_rr_arbiter_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin mux arbiter.
package mux8_rr_arbiter_pkg;

  localparam int N_REQ        = 8;
  localparam int SEL_W        = 3;
  localparam int HOLD_MAX_DEF = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    GRANT   = 2'b01,
    RELEASE = 2'b10
  } state_t;

  function automatic logic [N_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[sel] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux8_rr_arbiter_if.sv
// Request/data/grant bundle between the requesters (master) and the arbiter (slave).
interface mux8_rr_arbiter_if;
  import mux8_rr_arbiter_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] I;
  logic [N_REQ-1:0] gnt;
  logic [SEL_W-1:0] S;
  logic             Y;
  logic             valid;
  logic             busy;

  modport master (
    output req, I,
    input  gnt, S, Y, valid, busy
  );

  modport slave (
    input  req, I,
    output gnt, S, Y, valid, busy
  );

endinterface

// File: rtl/mux8_rr_arbiter_rr_pick8.sv
// Round-robin pick: first asserted request scanning from ptr upward, wrapping 7 -> 0.
module rr_pick8
  import mux8_rr_arbiter_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic [SEL_W-1:0] idx,
  output logic             any
);

  logic [N_REQ-1:0] rot;
  logic [SEL_W-1:0] off;

  // Rotate so that bit 0 of rot is the request at ptr.
  always_comb begin
    rot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rot[i] = req[SEL_W'(i) + ptr];
    end
  end

  // Priority-encode the lowest asserted rotated bit; scanning downward leaves the lowest one.
  always_comb begin
    off = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = SEL_W'(i);
    end
  end

  // Un-rotate: offset from ptr wraps naturally in SEL_W bits.
  assign idx = ptr + off;
  assign any = |req;

endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter sharing one 8:1 single-bit mux among 8 requesters, with a
// hold counter that caps an owner's tenure while anyone else is waiting.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no owner, gnt=0, valid dropped
//   GRANT   | one owner, I[S] sampled into Y every cycle, cnt advancing
//   RELEASE | one-cycle turnaround bubble, gnt=0, Y/valid from last grant
module mux8_rr_arbiter
  import mux8_rr_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = HOLD_MAX_DEF,
  parameter int CNT_W    = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  mux8_rr_arbiter_if.slave bus
);

  state_t           state_q, state_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [SEL_W-1:0] s_q, s_d;
  logic             y_q, y_d;
  logic             valid_q, valid_d;

  logic [SEL_W-1:0] pick_idx;
  logic             pick_any;
  logic             owner_req;
  logic             others_pending;
  logic             at_limit;

  rr_pick8 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign owner_req      = bus.req[s_q];
  assign others_pending = |(bus.req & ~onehot(s_q));
  assign at_limit       = (cnt_q == CNT_W'(HOLD_MAX - 1));

  // Next-state and next-output decode; every register holds unless a state says otherwise.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    s_d     = s_q;
    y_d     = y_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = onehot(pick_idx);
          s_d     = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end
      end

      GRANT: begin
        y_d     = bus.I[s_q];
        valid_d = 1'b1;
        cnt_d   = at_limit ? '0 : cnt_q + CNT_W'(1);
        // Owner dropping and hold expiry collapse into one release.
        if (!owner_req || (at_limit && others_pending)) begin
          gnt_d   = '0;
          ptr_d   = s_q + SEL_W'(1);
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (pick_any) begin
          gnt_d   = onehot(pick_idx);
          s_d     = pick_idx;
          cnt_d   = '0;
          state_d = GRANT;
        end else begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        gnt_d   = '0;
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, counter and output registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      s_q     <= '0;
      y_q     <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      s_q     <= s_d;
      y_q     <= y_d;
      valid_q <= valid_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.S     = s_q;
  assign bus.Y     = y_q;
  assign bus.valid = valid_q;
  assign bus.busy  = (state_q != IDLE);

endmodule
